// File: rtl/video_cfg_ctrl_if.sv
// AXI-Lite slave bus bundle for the video configuration controller.
// The slave modport is the register block side; the master modport is the host side.
interface video_cfg_ctrl_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] s_awaddr;
   logic              s_awvalid;
   logic              s_awready;
   logic [31:0]       s_wdata;
   logic [3:0]        s_wstrb;
   logic              s_wvalid;
   logic              s_wready;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;
   logic [ADDR_W-1:0] s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic [31:0]       s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rvalid;
   logic              s_rready;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      input  s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
      output s_arready, s_rdata, s_rresp, s_rvalid
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      output s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
      input  s_arready, s_rdata, s_rresp, s_rvalid
   );
endinterface

// File: rtl/video_cfg_ctrl.sv
// AXI-Lite register block for display timing and background colour: host writes land in
// shadow registers and are committed to the cfg_* outputs only on a frame_start pulse.
module video_cfg_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   video_cfg_ctrl_if.slave       s_axi,
   input  logic                  frame_start,
   output logic                  cfg_enable,
   output logic [11:0]           cfg_h_total,
   output logic [11:0]           cfg_h_active,
   output logic [11:0]           cfg_hs_start,
   output logic [11:0]           cfg_hs_end,
   output logic [11:0]           cfg_v_total,
   output logic [11:0]           cfg_v_active,
   output logic [11:0]           cfg_vs_start,
   output logic [11:0]           cfg_vs_end,
   output logic [23:0]           cfg_bg_color,
   output logic                  irq
);
   localparam logic [3:0] A_CTRL   = 4'd0;
   localparam logic [3:0] A_STATUS = 4'd1;
   localparam logic [3:0] A_HTIM   = 4'd2;
   localparam logic [3:0] A_HSYNC  = 4'd3;
   localparam logic [3:0] A_VTIM   = 4'd4;
   localparam logic [3:0] A_VSYNC  = 4'd5;
   localparam logic [3:0] A_BG     = 4'd6;
   localparam logic [3:0] A_COMMIT = 4'd7;
   localparam logic [3:0] A_FCNT   = 4'd8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   function automatic logic [31:0] f_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++)
         res[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      return res;
   endfunction

   wstate_t     r_wstate, w_wnext;
   rstate_t     r_rstate, w_rnext;
   logic        r_init;
   logic        r_aw_got, r_w_got;
   logic [3:0]  r_awidx;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [1:0]  r_bresp;
   logic [31:0] r_rdata;
   logic [1:0]  r_rresp;

   logic        r_sh_en, r_irq_en;
   logic [11:0] r_sh_h_total, r_sh_h_active, r_sh_hs_start, r_sh_hs_end;
   logic [11:0] r_sh_v_total, r_sh_v_active, r_sh_vs_start, r_sh_vs_end;
   logic [23:0] r_sh_bg;
   logic        r_cfg_en;
   logic [11:0] r_cfg_h_total, r_cfg_h_active, r_cfg_hs_start, r_cfg_hs_end;
   logic [11:0] r_cfg_v_total, r_cfg_v_active, r_cfg_vs_start, r_cfg_vs_end;
   logic [23:0] r_cfg_bg;
   logic        r_commit_pending, r_frame_flag;
   logic [15:0] r_frame_cnt;

   logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire, w_wr_ok, w_ar_ok;
   logic [3:0]  w_wr_idx, w_ar_idx, w_wr_strb;
   logic [31:0] w_wr_data, w_wr_word;
   logic [31:0] w_regs [0:15];
   logic        w_unused;

   assign w_unused = ^{s_axi.s_awaddr[ADDR_W-1:6], s_axi.s_awaddr[1:0],
                       s_axi.s_araddr[ADDR_W-1:6], s_axi.s_araddr[1:0]};

   assign w_aw_hs   = s_axi.s_awvalid & s_axi.s_awready;
   assign w_w_hs    = s_axi.s_wvalid & s_axi.s_wready;
   assign w_ar_hs   = s_axi.s_arvalid & s_axi.s_arready;
   assign w_wr_fire = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
   assign w_wr_idx  = r_aw_got ? r_awidx : s_axi.s_awaddr[5:2];
   assign w_wr_data = r_w_got ? r_wdata : s_axi.s_wdata;
   assign w_wr_strb = r_w_got ? r_wstrb : s_axi.s_wstrb;
   assign w_wr_ok   = (w_wr_idx <= A_FCNT);
   assign w_ar_idx  = s_axi.s_araddr[5:2];
   assign w_ar_ok   = (w_ar_idx <= A_FCNT);

   // Software-visible view of every register; COMMIT and undecoded slots read as zero.
   always_comb begin
      for (int i = 0; i < 16; i++) w_regs[i] = '0;
      w_regs[A_CTRL]   = {30'd0, r_irq_en, r_sh_en};
      w_regs[A_STATUS] = {30'd0, r_frame_flag, r_commit_pending};
      w_regs[A_HTIM]   = {4'd0, r_sh_h_total, 4'd0, r_sh_h_active};
      w_regs[A_HSYNC]  = {4'd0, r_sh_hs_end, 4'd0, r_sh_hs_start};
      w_regs[A_VTIM]   = {4'd0, r_sh_v_total, 4'd0, r_sh_v_active};
      w_regs[A_VSYNC]  = {4'd0, r_sh_vs_end, 4'd0, r_sh_vs_start};
      w_regs[A_BG]     = {8'd0, r_sh_bg};
      w_regs[A_FCNT]   = {16'd0, r_frame_cnt};
   end

   assign w_wr_word = f_merge(w_regs[w_wr_idx], w_wr_data, w_wr_strb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init   <= 1'b0;
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
      end else begin
         r_init   <= 1'b1;
         r_wstate <= w_wnext;
         r_rstate <= w_rnext;
      end
   end

   always_comb begin
      w_wnext = r_wstate;
      case (r_wstate)
         W_IDLE:  if (w_wr_fire) w_wnext = W_RESP;
         W_RESP:  if (s_axi.s_bready) w_wnext = W_IDLE;
         default: w_wnext = W_IDLE;
      endcase
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
         R_DATA:  if (s_axi.s_rready) w_rnext = R_IDLE;
         default: w_rnext = R_IDLE;
      endcase
   end

   always_comb begin
      s_axi.s_awready = 1'b0;
      s_axi.s_wready  = 1'b0;
      s_axi.s_bvalid  = 1'b0;
      s_axi.s_arready = 1'b0;
      s_axi.s_rvalid  = 1'b0;
      if (r_wstate == W_IDLE) begin
         s_axi.s_awready = r_init & ~r_aw_got;
         s_axi.s_wready  = r_init & ~r_w_got;
      end else begin
         s_axi.s_bvalid  = 1'b1;
      end
      if (r_rstate == R_IDLE) s_axi.s_arready = r_init;
      else                    s_axi.s_rvalid  = 1'b1;
   end

   assign s_axi.s_bresp = r_bresp;
   assign s_axi.s_rdata = r_rdata;
   assign s_axi.s_rresp = r_rresp;

   // AW and W may arrive in either order; whichever lands first is parked here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aw_got <= 1'b0;
         r_w_got  <= 1'b0;
         r_bresp  <= RESP_OKAY;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
      end else begin
         if (w_wr_fire) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (w_aw_hs) r_aw_got <= 1'b1;
            if (w_w_hs)  r_w_got  <= 1'b1;
         end
         if (w_ar_hs) begin
            r_rdata <= w_ar_ok ? w_regs[w_ar_idx] : 32'd0;
            r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_aw_hs) r_awidx <= s_axi.s_awaddr[5:2];
      if (w_w_hs) begin
         r_wdata <= s_axi.s_wdata;
         r_wstrb <= s_axi.s_wstrb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_en <= 1'b0;           r_irq_en <= 1'b0;
         r_sh_h_total  <= 12'd1344; r_sh_h_active <= 12'd1024;
         r_sh_hs_start <= 12'd1048; r_sh_hs_end   <= 12'd1184;
         r_sh_v_total  <= 12'd806;  r_sh_v_active <= 12'd768;
         r_sh_vs_start <= 12'd771;  r_sh_vs_end   <= 12'd777;
         r_sh_bg <= 24'd0;
         r_cfg_en <= 1'b0;
         r_cfg_h_total  <= 12'd1344; r_cfg_h_active <= 12'd1024;
         r_cfg_hs_start <= 12'd1048; r_cfg_hs_end   <= 12'd1184;
         r_cfg_v_total  <= 12'd806;  r_cfg_v_active <= 12'd768;
         r_cfg_vs_start <= 12'd771;  r_cfg_vs_end   <= 12'd777;
         r_cfg_bg <= 24'd0;
         r_commit_pending <= 1'b0;
         r_frame_flag     <= 1'b0;
         r_frame_cnt      <= 16'd0;
      end else begin
         if (w_wr_fire) begin
            case (w_wr_idx)
               A_CTRL:   begin r_sh_en <= w_wr_word[0]; r_irq_en <= w_wr_word[1]; end
               A_STATUS: if (w_wr_data[1] && w_wr_strb[0]) r_frame_flag <= 1'b0;
               A_HTIM:   begin r_sh_h_active <= w_wr_word[11:0]; r_sh_h_total <= w_wr_word[27:16]; end
               A_HSYNC:  begin r_sh_hs_start <= w_wr_word[11:0]; r_sh_hs_end  <= w_wr_word[27:16]; end
               A_VTIM:   begin r_sh_v_active <= w_wr_word[11:0]; r_sh_v_total <= w_wr_word[27:16]; end
               A_VSYNC:  begin r_sh_vs_start <= w_wr_word[11:0]; r_sh_vs_end  <= w_wr_word[27:16]; end
               A_BG:     r_sh_bg <= w_wr_word[23:0];
               default:  ;
            endcase
         end
         // Commit samples the shadows and pending flag as they stood before this edge's write.
         if (frame_start) begin
            r_frame_flag <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            if (r_commit_pending) begin
               r_commit_pending <= 1'b0;
               r_cfg_en <= r_sh_en;
               r_cfg_h_total  <= r_sh_h_total;  r_cfg_h_active <= r_sh_h_active;
               r_cfg_hs_start <= r_sh_hs_start; r_cfg_hs_end   <= r_sh_hs_end;
               r_cfg_v_total  <= r_sh_v_total;  r_cfg_v_active <= r_sh_v_active;
               r_cfg_vs_start <= r_sh_vs_start; r_cfg_vs_end   <= r_sh_vs_end;
               r_cfg_bg <= r_sh_bg;
            end
         end
         if (w_wr_fire && (w_wr_idx == A_COMMIT)) r_commit_pending <= 1'b1;
      end
   end

   assign cfg_enable   = r_cfg_en;
   assign cfg_h_total  = r_cfg_h_total;
   assign cfg_h_active = r_cfg_h_active;
   assign cfg_hs_start = r_cfg_hs_start;
   assign cfg_hs_end   = r_cfg_hs_end;
   assign cfg_v_total  = r_cfg_v_total;
   assign cfg_v_active = r_cfg_v_active;
   assign cfg_vs_start = r_cfg_vs_start;
   assign cfg_vs_end   = r_cfg_vs_end;
   assign cfg_bg_color = r_cfg_bg;
   assign irq          = r_frame_flag & r_irq_en;
endmodule
